// File: rtl/feistel_round_engine_if.sv
// Handshake, operand and sub-key RAM signals of the Feistel round engine.
// Latency: none, pure wiring bundle.
// Backpressure: none carried here; ap_start is only honoured while ap_idle is high.
interface feistel_round_engine_if #(
  parameter int HALF_W = 32,
  parameter int KEY_W  = 64,
  parameter int ADDR_W = 4
) ();
  logic                  ap_start;
  logic                  ap_done;
  logic                  ap_idle;
  logic                  ap_ready;
  logic                  mode;
  logic [HALF_W-1:0]     L;
  logic [HALF_W-1:0]     R;
  logic [ADDR_W-1:0]     sub_key_address0;
  logic                  sub_key_ce0;
  logic [KEY_W-1:0]      sub_key_q0;
  logic [2*HALF_W-1:0]   ap_return;

  // Environment side: issues blocks and serves the sub-key RAM.
  modport master (
    output ap_start, mode, L, R, sub_key_q0,
    input  ap_done, ap_idle, ap_ready, sub_key_address0, sub_key_ce0, ap_return
  );

  // Engine side.
  modport slave (
    input  ap_start, mode, L, R, sub_key_q0,
    output ap_done, ap_idle, ap_ready, sub_key_address0, sub_key_ce0, ap_return
  );
endinterface

// File: rtl/feistel_round_engine.sv
// Feistel network over {L,R}, ROUNDS rounds at one per cycle, keys from a 1-cycle-latency RAM.
// Latency: start sampled in cycle 0, ap_done/ap_ready pulse in cycle ROUNDS+1; one block per ROUNDS+2 cycles.
// Backpressure: none; ap_start is honoured only in IDLE, requests during RUN/DONE are dropped.
module feistel_round_engine #(
  parameter int HALF_W = 32,
  parameter int KEY_W  = 64,
  parameter int ROUNDS = 16,
  parameter int ADDR_W = 4
) (
  input logic                  ap_clk,
  input logic                  ap_rst,
  feistel_round_engine_if.slave bus
);

  localparam int                CNT_W     = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(ROUNDS - 1);
  localparam logic [ADDR_W-1:0] DEC_FIRST = ADDR_W'(ROUNDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [HALF_W-1:0]   l_q, r_q;
  logic                mode_q;
  logic [ADDR_W-1:0]   addr_q, addr_nxt;
  logic [2*HALF_W-1:0] ret_q;
  logic                ce0_c, done_c, idle_c;
  logic                last_round;

  // Round function: the key arriving from RAM this cycle belongs to round cnt.
  logic [HALF_W-1:0]   key_lo, key_hi, f_mix, f_val, r_nxt;
  assign key_lo     = bus.sub_key_q0[HALF_W-1:0];
  assign key_hi     = bus.sub_key_q0[KEY_W-1 -: HALF_W];
  assign f_mix      = r_q ^ key_lo;
  assign f_val      = {f_mix[HALF_W-4:0], f_mix[HALF_W-1:HALF_W-3]} + key_hi;
  assign r_nxt      = l_q ^ f_val;
  assign last_round = (cnt == LAST_CNT);

  // State register.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state, key fetch and handshake outputs. The fetch for round n+1 is
  // issued while round n computes, so the RAM latency is fully hidden.
  always_comb begin
    state_nxt = state;
    ce0_c     = 1'b0;
    addr_nxt  = addr_q;
    done_c    = 1'b0;
    idle_c    = 1'b0;
    case (state)
      IDLE: begin
        idle_c = 1'b1;
        if (bus.ap_start) begin
          ce0_c     = 1'b1;
          addr_nxt  = bus.mode ? DEC_FIRST : '0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (!last_round) begin
          ce0_c    = 1'b1;
          addr_nxt = mode_q ? (addr_q - ADDR_W'(1)) : (addr_q + ADDR_W'(1));
        end else begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand latch at start, one round per RUN cycle, result capture
  // with the final half swap as the last round retires.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      cnt    <= '0;
      l_q    <= '0;
      r_q    <= '0;
      mode_q <= 1'b0;
      addr_q <= '0;
      ret_q  <= '0;
    end else begin
      addr_q <= addr_nxt;
      case (state)
        IDLE: begin
          if (bus.ap_start) begin
            l_q    <= bus.L;
            r_q    <= bus.R;
            mode_q <= bus.mode;
            cnt    <= '0;
          end
        end
        RUN: begin
          l_q <= r_q;
          r_q <= r_nxt;
          if (!last_round) cnt   <= cnt + CNT_W'(1);
          else             ret_q <= {r_nxt, r_q};
        end
        default: ;
      endcase
    end
  end

  assign bus.ap_idle          = idle_c;
  assign bus.ap_done          = done_c;
  assign bus.ap_ready         = done_c;
  assign bus.sub_key_ce0      = ce0_c;
  assign bus.sub_key_address0 = addr_nxt;
  assign bus.ap_return        = ret_q;

endmodule

// File: tb/tb_feistel_round_engine.sv
// Bench for feistel_round_engine: directed blocks against a cipher/timeline model.
// Latency: checks every cycle at the falling edge; ap_done expected ROUNDS+1 cycles after start.
// Backpressure: exercises held ap_start and input toggling while a block is in flight.
module tb_feistel_round_engine;

  localparam int N = 16;

  logic ap_clk = 1'b0;
  logic ap_rst;
  always #5 ap_clk = ~ap_clk;

  feistel_round_engine_if #(.HALF_W(32), .KEY_W(64), .ADDR_W(4)) ifc  ();
  feistel_round_engine_if #(.HALF_W(32), .KEY_W(64), .ADDR_W(4)) ifc1 ();

  feistel_round_engine #(.HALF_W(32), .KEY_W(64), .ROUNDS(N), .ADDR_W(4)) dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (ifc)
  );

  feistel_round_engine #(.HALF_W(32), .KEY_W(64), .ROUNDS(1), .ADDR_W(4)) dut1 (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (ifc1)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [63:0] kmem [N];

  // Sub-key RAMs: random keys for the main engine, all-zero for the 1-round one.
  always @(posedge ap_clk) if (ifc.sub_key_ce0) ifc.sub_key_q0 <= kmem[ifc.sub_key_address0];
  assign ifc1.sub_key_q0 = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] f_fn(input logic [31:0] r, input logic [63:0] k);
    logic [31:0] x;
    x = r ^ k[31:0];
    return ((x << 3) | (x >> 29)) + k[63:32];
  endfunction

  // Whole-block cipher: n rounds, keys in order (or reversed to decrypt), swapped result.
  function automatic logic [63:0] model_blk(input logic [31:0] l_in, input logic [31:0] r_in,
                                            input bit dec, input int n, input bit zero_keys);
    logic [31:0] l, r, t;
    logic [63:0] k;
    l = l_in;
    r = r_in;
    for (int i = 0; i < n; i++) begin
      k = zero_keys ? 64'd0 : kmem[dec ? (n - 1 - i) : i];
      t = l ^ f_fn(r, k);
      l = r;
      r = t;
    end
    return {r, l};
  endfunction

  // Timeline model of the main engine: p < 0 idle, 1..N run cycles, N+1 done.
  int          p = -1;
  bit          m_dec;
  logic [63:0] exp_ret = 64'd0;
  logic [63:0] pend_ret;

  always @(negedge ap_clk) begin
    if (ap_rst) begin
      p       = -1;
      exp_ret = 64'd0;
      chk("rst_idle", ifc.ap_idle, 1);
      chk("rst_done", ifc.ap_done, 0);
      chk("rst_ce0",  ifc.sub_key_ce0, 0);
      chk("rst_addr", ifc.sub_key_address0, 0);
      chk("rst_ret",  ifc.ap_return, 0);
    end else if (p < 0) begin
      chk("idle_idle",  ifc.ap_idle, 1);
      chk("idle_done",  ifc.ap_done, 0);
      chk("idle_ready", ifc.ap_ready, 0);
      chk("idle_ret",   ifc.ap_return, exp_ret);
      if (ifc.ap_start) begin
        chk("start_ce0",  ifc.sub_key_ce0, 1);
        chk("start_addr", ifc.sub_key_address0, ifc.mode ? N - 1 : 0);
        m_dec    = ifc.mode;
        pend_ret = model_blk(ifc.L, ifc.R, ifc.mode, N, 1'b0);
        p        = 1;
      end else begin
        chk("idle_ce0", ifc.sub_key_ce0, 0);
      end
    end else if (p <= N) begin
      chk("run_idle", ifc.ap_idle, 0);
      chk("run_done", ifc.ap_done, 0);
      chk("run_ce0",  ifc.sub_key_ce0, (p < N) ? 1 : 0);
      if (p < N) chk("run_addr", ifc.sub_key_address0, m_dec ? (N - 1 - p) : p);
      chk("run_ret_hold", ifc.ap_return, exp_ret);
      p++;
    end else begin
      exp_ret = pend_ret;
      chk("done_done",  ifc.ap_done, 1);
      chk("done_ready", ifc.ap_ready, 1);
      chk("done_idle",  ifc.ap_idle, 0);
      chk("done_ce0",   ifc.sub_key_ce0, 0);
      chk("done_ret",   ifc.ap_return, exp_ret);
      p = -1;
    end
  end

  // Issue one block on the main engine and return its result at the done cycle.
  task automatic run_block(input logic [31:0] l, input logic [31:0] r, input bit m,
                           input bit hold, output logic [63:0] res);
    bit got;
    @(posedge ap_clk); #1;
    ifc.ap_start = 1'b1;
    ifc.L        = l;
    ifc.R        = r;
    ifc.mode     = m;
    @(posedge ap_clk); #1;
    if (!hold) ifc.ap_start = 1'b0;
    ifc.L    = $urandom;
    ifc.R    = $urandom;
    ifc.mode = ~m;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge ap_clk);
      if (ifc.ap_done) got = 1'b1;
      else if (hold) begin
        @(posedge ap_clk); #1;
        ifc.L    = $urandom;
        ifc.R    = $urandom;
        ifc.mode = $urandom_range(0, 1);
      end
    end
    chk("done_timeout", {63'd0, got}, 64'd1);
    res = ifc.ap_return;
  endtask

  logic [63:0] res_enc, res_dec, res_tmp, res_hold;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ap_rst        = 1'b1;
    ifc.ap_start  = 1'b0;
    ifc.mode      = 1'b0;
    ifc.L         = '0;
    ifc.R         = '0;
    ifc1.ap_start = 1'b0;
    ifc1.mode     = 1'b0;
    ifc1.L        = '0;
    ifc1.R        = '0;
    for (int i = 0; i < N; i++) kmem[i] = {$urandom, $urandom};
    repeat (3) @(posedge ap_clk);
    #1 ap_rst = 1'b0;

    // Hand-computed pins of the model itself.
    chk("pin_f_rot",  {32'd0, f_fn(32'h8000_0001, 64'h0000_0005_0000_0001)}, 64'h9);
    chk("pin_f_wrap", {32'd0, f_fn(32'hFFFF_FFFF, 64'h0000_0001_0000_0000)}, 64'h0);
    chk("pin_r1",     model_blk(32'd1, 32'd2, 1'b0, 1, 1'b1), 64'h00000011_00000002);

    // Single-round engine, zero keys, L=1 R=2.
    @(posedge ap_clk); #1;
    ifc1.ap_start = 1'b1;
    ifc1.L        = 32'd1;
    ifc1.R        = 32'd2;
    @(negedge ap_clk);
    chk("r1_c0_idle", ifc1.ap_idle, 1);
    chk("r1_c0_ce0",  ifc1.sub_key_ce0, 1);
    chk("r1_c0_addr", ifc1.sub_key_address0, 0);
    @(posedge ap_clk); #1;
    ifc1.ap_start = 1'b0;
    ifc1.L        = 32'hDEAD_BEEF;
    @(negedge ap_clk);
    chk("r1_c1_done", ifc1.ap_done, 0);
    chk("r1_c1_ce0",  ifc1.sub_key_ce0, 0);
    chk("r1_c1_idle", ifc1.ap_idle, 0);
    @(negedge ap_clk);
    chk("r1_c2_done",  ifc1.ap_done, 1);
    chk("r1_c2_ready", ifc1.ap_ready, 1);
    chk("r1_c2_ret",   ifc1.ap_return, 64'h00000011_00000002);
    @(negedge ap_clk);
    chk("r1_c3_idle", ifc1.ap_idle, 1);
    chk("r1_c3_done", ifc1.ap_done, 0);
    chk("r1_c3_ret",  ifc1.ap_return, 64'h00000011_00000002);

    // Round trip on the main engine.
    run_block(32'h0123_4567, 32'h89AB_CDEF, 1'b0, 1'b0, res_enc);
    chk("enc_model", res_enc, model_blk(32'h0123_4567, 32'h89AB_CDEF, 1'b0, N, 1'b0));
    run_block(res_enc[63:32], res_enc[31:0], 1'b1, 1'b0, res_dec);
    chk("roundtrip", res_dec, 64'h01234567_89ABCDEF);

    // A few more directed blocks in both directions.
    run_block(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, res_tmp);
    run_block(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, res_tmp);
    run_block(32'hA5A5_5A5A, 32'h1357_9BDF, 1'b0, 1'b0, res_tmp);

    // Held start with inputs toggling mid-block, then an immediate back-to-back block.
    run_block(32'hCAFE_F00D, 32'h1234_5678, 1'b0, 1'b1, res_hold);
    chk("hold_result", res_hold, model_blk(32'hCAFE_F00D, 32'h1234_5678, 1'b0, N, 1'b0));
    run_block(32'h0BAD_C0DE, 32'h7777_8888, 1'b1, 1'b0, res_tmp);
    chk("b2b_result", res_tmp, model_blk(32'h0BAD_C0DE, 32'h7777_8888, 1'b1, N, 1'b0));

    // Reset in the middle of a block, then a clean block afterwards.
    @(posedge ap_clk); #1;
    ifc.ap_start = 1'b1;
    ifc.L        = 32'h5555_AAAA;
    ifc.R        = 32'h3333_CCCC;
    ifc.mode     = 1'b0;
    @(posedge ap_clk); #1;
    ifc.ap_start = 1'b0;
    repeat (5) @(posedge ap_clk);
    #1 ap_rst = 1'b1;
    @(negedge ap_clk);
    chk("midrst_ret",  ifc.ap_return, 0);
    chk("midrst_idle", ifc.ap_idle, 1);
    @(posedge ap_clk); #1 ap_rst = 1'b0;
    repeat (20) begin
      @(negedge ap_clk);
      chk("postrst_no_done", ifc.ap_done, 0);
    end
    run_block(32'h0123_4567, 32'h89AB_CDEF, 1'b0, 1'b0, res_tmp);
    chk("postrst_result", res_tmp, res_enc);

    repeat (3) @(posedge ap_clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
